usequencer_stack: RTL and testbench

//  Parametrised microprogram sequencer for the multicycle ARM controller. It generalises the

---
 rtl/usequencer_stack.sv | 154 +++++++++++++++
 tb/tb_usequencer_stack.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/usequencer_stack.sv
// Microprogram sequencer: registered uPC with dispatch, conditional branches and a
// micro-subroutine return stack; the control word is passed straight through.
module usequencer_stack #(
  parameter int             AW      = 5,
  parameter int             CW      = 24,
  parameter int             NDISP   = 2,
  parameter int             NCOND   = 4,
  parameter int             SDEPTH  = 4,
  parameter logic [AW-1:0]  RST_ADR = '1,
  localparam int            CSW     = $clog2(NCOND),
  localparam int            PW      = $clog2(SDEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [AW-1:0]         uaddr,
  input  logic [CW+3+CSW+AW-1:0] uinstr,
  input  logic [NDISP*AW-1:0]   disp_adr,
  input  logic [NCOND-1:0]      cond,
  input  logic                  stall,
  input  logic                  err_clr,
  output logic [CW-1:0]         ctrl,
  output logic                  ctrl_vld,
  output logic [PW-1:0]         sdepth_o,
  output logic                  ovf_err,
  output logic                  unf_err
);

  localparam int IW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NEXT  = 3'b000,
    OP_JUMP  = 3'b001,
    OP_DISP  = 3'b010,
    OP_CJMP  = 3'b011,
    OP_CALL  = 3'b100,
    OP_RET   = 3'b101,
    OP_CJMPN = 3'b110,
    OP_WAIT  = 3'b111
  } op_e;

  logic [AW-1:0] r_uaddr;
  logic [PW-1:0] r_sp;
  logic          r_ovf;
  logic          r_unf;
  logic [AW-1:0] r_stack [2**IW];

  op_e           w_op;
  logic [CSW-1:0] w_csel;
  logic [AW-1:0] w_tgt;
  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_disp;
  logic [AW-1:0] w_top;
  logic [PW-1:0] w_sp_dec;
  logic          w_cbit;
  logic          w_full;
  logic          w_empty;
  logic [AW-1:0] w_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_unf_set;

  assign ctrl     = uinstr[AW+CSW+3 +: CW];
  assign w_op     = op_e'(uinstr[AW+CSW +: 3]);
  assign w_csel   = uinstr[AW +: CSW];
  assign w_tgt    = uinstr[AW-1:0];
  assign w_inc    = r_uaddr + AW'(1);
  assign w_full   = (r_sp == PW'(SDEPTH));
  assign w_empty  = (r_sp == '0);
  assign w_sp_dec = r_sp - PW'(1);
  assign w_top    = r_stack[w_sp_dec[IW-1:0]];
  assign w_cbit   = (int'(w_csel) < NCOND) ? cond[w_csel] : 1'b0;

  // The whole tgt field is the slot index, so an out-of-range target falls back
  // to slot 0 instead of aliasing onto another slot.
  always_comb begin
    w_disp = disp_adr[AW-1:0];
    for (int i = 1; i < NDISP; i++) begin
      if (int'(w_tgt) == i) w_disp = disp_adr[i*AW +: AW];
    end
  end

  always_comb begin
    w_nxt     = w_inc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (w_op)
      OP_NEXT:  w_nxt = w_inc;
      OP_JUMP:  w_nxt = w_tgt;
      OP_DISP:  w_nxt = w_disp;
      OP_CJMP:  w_nxt = w_cbit ? w_tgt : w_inc;
      OP_CALL: begin
        w_nxt = w_tgt;
        if (w_full) w_ovf_set = 1'b1;
        else        w_push    = 1'b1;
      end
      OP_RET: begin
        if (w_empty) begin
          w_nxt     = RST_ADR;
          w_unf_set = 1'b1;
        end else begin
          w_nxt = w_top;
          w_pop = 1'b1;
        end
      end
      OP_CJMPN: w_nxt = w_cbit ? w_inc : w_tgt;
      OP_WAIT:  w_nxt = w_cbit ? w_inc : r_uaddr;
      default:  w_nxt = w_inc;
    endcase
    if (stall) begin
      w_nxt     = r_uaddr;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_uaddr <= RST_ADR;
      r_sp    <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_uaddr <= w_nxt;
      if (w_push)     r_sp <= r_sp + PW'(1);
      else if (w_pop) r_sp <= w_sp_dec;
      // A fresh error wins over a clear arriving in the same cycle.
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
      if (w_unf_set)    r_unf <= 1'b1;
      else if (err_clr) r_unf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[IW-1:0]] <= w_inc;
  end

  // ctrl_vld is a strobe, not a handshake: the datapath commits ctrl only when it is 1.
  assign ctrl_vld = ~stall;
  assign uaddr    = r_uaddr;
  assign sdepth_o = r_sp;
  assign ovf_err  = r_ovf;
  assign unf_err  = r_unf;

  a_uinstr_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(uinstr));
  a_uaddr_known:  assert property (@(posedge clk) disable iff (reset) !$isunknown(r_uaddr));
  a_sp_bound:     assert property (@(posedge clk) disable iff (reset) r_sp <= PW'(SDEPTH));

endmodule

// File: tb/tb_usequencer_stack.sv
// Bench for usequencer_stack: directed scenarios plus random ops, checked against a
// queue-based reference model through an expected-response scoreboard.
module tb_usequencer_stack;

  localparam int AW = 5, CW = 24, NDISP = 2, NCOND = 4, SDEPTH = 4;
  localparam int CSW = 2, PW = 3, UW = CW + 3 + CSW + AW;
  localparam int RST = 31;
  localparam int EW  = CW + 3 + PW + AW;
  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, DISP = 3'd2, CJMP = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, CJMPN = 3'd6, WAIT = 3'd7;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [AW-1:0]       uaddr;
  logic [UW-1:0]       uinstr = '0;
  logic [NDISP*AW-1:0] disp_adr = '0;
  logic [NCOND-1:0]    cond = '0;
  logic                stall = 1'b0;
  logic                err_clr = 1'b0;
  logic [CW-1:0]       ctrl;
  logic                ctrl_vld;
  logic [PW-1:0]       sdepth_o;
  logic                ovf_err;
  logic                unf_err;

  usequencer_stack dut (
    .clk(clk), .reset(reset), .uaddr(uaddr), .uinstr(uinstr), .disp_adr(disp_adr),
    .cond(cond), .stall(stall), .err_clr(err_clr), .ctrl(ctrl), .ctrl_vld(ctrl_vld),
    .sdepth_o(sdepth_o), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  int  m_pc = RST;
  int  m_stk[$];
  bit  m_ovf = 1'b0;
  bit  m_unf = 1'b0;
  logic [NDISP*AW-1:0] g_disp = '0;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver: called at a falling edge, applies one microinstruction and predicts the result
  task automatic cyc(input logic [2:0] op, input int csel, input int tgt,
                     input logic [NCOND-1:0] c = '0, input logic st = 1'b0,
                     input logic clr = 1'b0);
    logic [CW-1:0] cw;
    int inc, nxt, idx;
    bit cb, ovs, uns;
    cw = CW'($urandom);
    uinstr   = {cw, op, CSW'(csel), AW'(tgt)};
    cond     = c;
    stall    = st;
    err_clr  = clr;
    disp_adr = g_disp;
    inc = (m_pc + 1) % 32;
    cb  = (csel < NCOND) ? c[csel] : 1'b0;
    nxt = m_pc;
    ovs = 1'b0;
    uns = 1'b0;
    if (!st) begin
      case (op)
        NEXT:  nxt = inc;
        JUMP:  nxt = tgt;
        DISP: begin
          idx = (tgt < NDISP) ? tgt : 0;
          nxt = int'((disp_adr >> (idx * AW)) & 10'h1f);
        end
        CJMP:  nxt = cb ? tgt : inc;
        CALL: begin
          if (m_stk.size() < SDEPTH) m_stk.push_back(inc);
          else ovs = 1'b1;
          nxt = tgt;
        end
        RET: begin
          if (m_stk.size() > 0) nxt = m_stk.pop_back();
          else begin
            nxt = RST;
            uns = 1'b1;
          end
        end
        CJMPN: nxt = cb ? inc : tgt;
        default: nxt = cb ? inc : m_pc;
      endcase
    end
    m_ovf = ovs ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = uns ? 1'b1 : (clr ? 1'b0 : m_unf);
    m_pc  = nxt;
    exp_q.push_back({cw, ~st, m_ovf, m_unf, PW'(m_stk.size()), AW'(m_pc)});
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("queue_drain", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // asserted at a falling edge; checks the asynchronous effect before any clock edge
  task automatic do_reset();
    reset   = 1'b1;
    uinstr  = '0;
    stall   = 1'b0;
    err_clr = 1'b0;
    #1;
    check("reset_uaddr", 64'(uaddr), 64'(RST));
    check("reset_depth", 64'(sdepth_o), 64'd0);
    check("reset_ovf", 64'(ovf_err), 64'd0);
    check("reset_unf", 64'(unf_err), 64'd0);
    m_pc  = RST;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // monitor: one expected entry per applied microinstruction
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("uaddr", 64'(uaddr), 64'(e[AW-1:0]));
        check("sdepth", 64'(sdepth_o), 64'(e[AW +: PW]));
        check("unf_err", 64'(unf_err), 64'(e[AW+PW]));
        check("ovf_err", 64'(ovf_err), 64'(e[AW+PW+1]));
        check("ctrl_vld", 64'(ctrl_vld), 64'(e[AW+PW+2]));
        check("ctrl", 64'(ctrl), 64'(e[AW+PW+3 +: CW]));
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();

    // sequential count with wrap 31 -> 0
    for (int i = 0; i < 3; i++) cyc(NEXT, 0, 0);

    // dispatch, including an out-of-range slot
    g_disp = {5'd9, 5'd6};
    cyc(DISP, 0, 1);
    cyc(DISP, 0, 0);
    cyc(DISP, 0, 3);

    // call/return, then overflow and LIFO unwind
    cyc(JUMP, 0, 4);
    cyc(CALL, 0, 20);
    cyc(RET, 0, 0);
    for (int i = 0; i < 5; i++) cyc(CALL, 0, 10 + 2 * i);
    for (int i = 0; i < 4; i++) cyc(RET, 0, 0);
    cyc(NEXT, 0, 0, '0, 1'b0, 1'b1);

    // underflow, clear racing a new error, then plain clear
    cyc(RET, 0, 0);
    cyc(RET, 0, 0, '0, 1'b0, 1'b1);
    cyc(NEXT, 0, 0, '0, 1'b0, 1'b1);

    // wait and conditional jumps
    cyc(JUMP, 0, 8);
    for (int i = 0; i < 3; i++) cyc(WAIT, 2, 0, 4'b1011);
    cyc(WAIT, 2, 0, 4'b0100);
    cyc(CJMP, 1, 20, 4'b0010);
    cyc(CJMP, 1, 3, 4'b1101);
    cyc(CJMPN, 1, 7, 4'b0010);
    cyc(CJMPN, 1, 14, 4'b1101);

    // stalled call, then real calls and an asynchronous reset mid-stack
    cyc(CALL, 0, 25, '0, 1'b1);
    cyc(CALL, 0, 25, '0, 1'b1, 1'b1);
    cyc(CALL, 0, 25);
    cyc(CALL, 0, 3);
    drain();
    do_reset();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      g_disp = NDISP*AW'($urandom);
      cyc(3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 31),
          4'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
